// File: rtl/store_buffer_pkg.sv
// Shared defaults for the store buffer: geometry and the doubleword offset
// used when matching load addresses against buffered stores.
package store_buffer_pkg;
    localparam int SB_DEPTH  = 4;
    localparam int SB_AW     = 64;
    localparam int SB_DW     = 64;
    localparam int SB_DW_OFS = 3;
endpackage

// File: rtl/store_buffer_if.sv
// Core/memory-side handshake bundle of the store buffer: store enqueue,
// load forwarding lookup and the write port toward data memory.
interface store_buffer_if #(
    parameter int AW = store_buffer_pkg::SB_AW,
    parameter int DW = store_buffer_pkg::SB_DW
);
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          mem_wvalid;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wready;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_wready,
        input  st_ready, ld_hit, ld_data, mem_wvalid, mem_waddr, mem_wdata
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_wready,
        output st_ready, ld_hit, ld_data, mem_wvalid, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/store_buffer_fwd_match.sv
// Youngest-match select over the occupied entries for store-to-load forwarding.
// Latency: combinational.
// Backpressure: none; pure lookup.
module sb_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic [DEPTH-1:0]                 valid,
    input  logic [DEPTH-1:0][AW-1:0]         ent_addr,
    input  logic [DEPTH-1:0][DW-1:0]         ent_data,
    input  logic [$clog2(DEPTH)-1:0]         head,
    input  logic [$clog2(DEPTH)-1:0]         tail,
    input  logic [AW-1:0]                    ld_addr,
    output logic                             hit,
    output logic [DW-1:0]                    data
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] occ;
    logic [PW:0]   span;
    logic [PW-1:0] idx;

    // Walk oldest to youngest so a later (younger) match overwrites an older one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        occ  = tail - head;
        span = (occ == '0 && valid[head]) ? (PW+1)'(DEPTH) : {1'b0, occ};
        for (int o = 0; o < DEPTH; o++) begin
            idx = head + PW'(o);
            if ((PW+1)'(o) < span && valid[idx] &&
                (((ent_addr[idx] ^ ld_addr) >> SB_DW_OFS) == '0)) begin
                hit  = 1'b1;
                data = ent_data[idx];
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between core and data memory with load forwarding.
// Latency: enqueue to mem_wvalid is 1 cycle; forwarding is combinational.
// Backpressure: st_ready drops when full; stores offered while full are dropped and flag ovf.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                   clk,
    input  logic                   reset,
    store_buffer_if.slave          bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]            head;
    logic [PW-1:0]            tail;
    logic [DEPTH-1:0]         valid;
    logic [DEPTH-1:0][AW-1:0] ent_addr;
    logic [DEPTH-1:0][DW-1:0] ent_data;
    logic                     full;
    logic                     empty;
    logic                     enq;
    logic                     deq;
    logic                     fwd_hit;
    logic [DW-1:0]            fwd_data;

    assign full           = (count == (PW+1)'(DEPTH));
    assign empty          = (count == '0);
    assign bus.st_ready   = !full;
    assign enq            = bus.st_valid && !full;
    assign bus.mem_wvalid = !empty;
    assign deq            = bus.mem_wvalid && bus.mem_wready;
    assign bus.mem_waddr  = ent_addr[head];
    assign bus.mem_wdata  = ent_data[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            valid    <= '0;
            ent_addr <= '0;
            ent_data <= '0;
            ovf      <= 1'b0;
        end else begin
            if (enq) begin
                ent_addr[tail] <= bus.st_addr;
                ent_data[tail] <= bus.st_data;
                valid[tail]    <= 1'b1;
                tail           <= tail + PW'(1);
            end
            // head and tail never alias here: enq needs !full, deq needs !empty.
            if (deq) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            if (enq && !deq) begin
                count <= count + (PW+1)'(1);
            end else if (deq && !enq) begin
                count <= count - (PW+1)'(1);
            end
            if (bus.st_valid && full) begin
                ovf <= 1'b1;
            end
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .valid    (valid),
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .head     (head),
        .tail     (tail),
        .ld_addr  (bus.ld_addr),
        .hit      (fwd_hit),
        .data     (fwd_data)
    );

    assign bus.ld_hit  = bus.ld_valid && fwd_hit;
    assign bus.ld_data = bus.ld_hit ? fwd_data : '0;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int DW    = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] count;
    logic       ovf;

    store_buffer_if #(.AW(AW), .DW(DW)) sb ();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb),
        .count (count),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf;

    task automatic idle_inputs();
        sb.st_valid   = 1'b0;
        sb.st_addr    = '0;
        sb.st_data    = '0;
        sb.ld_valid   = 1'b0;
        sb.ld_addr    = '0;
        sb.mem_wready = 1'b0;
    endtask

    // Advance one rising edge and apply the same edge to the reference model.
    task automatic tick();
        bit full;
        bit deq;
        @(posedge clk);
        full = (mq.size() == DEPTH);
        deq  = (mq.size() > 0) && sb.mem_wready;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (sb.st_valid && full) m_ovf = 1'b1;
            if (deq) void'(mq.pop_front());
            if (sb.st_valid && !full) mq.push_back('{sb.st_addr, sb.st_data});
        end
    endtask

    // Youngest buffered store in the same doubleword as the load.
    function automatic void m_fwd(input logic [AW-1:0] la, output bit hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a[AW-1:3] == la[AW-1:3]) begin
                hit = 1'b1;
                d   = mq[i].d;
                break;
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wr);
        @(negedge clk);
        idle_inputs();
        sb.st_valid = 1'b1; sb.st_addr = a; sb.st_data = d; sb.mem_wready = wr;
        tick();
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        sb.ld_valid = 1'b1;
        sb.ld_addr  = '0;
        #1;
        n_checks++; if (sb.st_ready !== 1'b1) begin n_fail++; $display("FAIL rst_st_ready: got %b want 1", sb.st_ready); end
        n_checks++; if (sb.mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wvalid: got %b want 0", sb.mem_wvalid); end
        n_checks++; if (sb.mem_waddr !== '0 || sb.mem_wdata !== '0) begin n_fail++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", sb.mem_waddr, sb.mem_wdata); end
        n_checks++; if (sb.ld_hit !== 1'b0 || sb.ld_data !== '0) begin n_fail++; $display("FAIL rst_ld: got %b/%h want 0/0", sb.ld_hit, sb.ld_data); end
        n_checks++; if (count !== 3'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rst_count_ovf: got %0d/%b want 0/0", count, ovf); end
        tick();
    endtask

    task automatic test_single();
        @(negedge clk);
        idle_inputs();
        sb.st_valid = 1'b1; sb.st_addr = 64'h10; sb.st_data = 64'hAA; sb.mem_wready = 1'b1;
        #1;
        n_checks++; if (sb.mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got %b want 0", sb.mem_wvalid); end
        tick();
        @(negedge clk);
        idle_inputs();
        sb.mem_wready = 1'b1;
        #1;
        n_checks++; if (sb.mem_wvalid !== 1'b1 || sb.mem_waddr !== 64'h10 || sb.mem_wdata !== 64'hAA)
            begin n_fail++; $display("FAIL single_mem: got %b %h %h want 1 10 aa", sb.mem_wvalid, sb.mem_waddr, sb.mem_wdata); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count1: got %0d want 1", count); end
        tick();
        @(negedge clk);
        #1;
        n_checks++; if (count !== 3'd0 || sb.mem_wvalid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %0d/%b want 0/0", count, sb.mem_wvalid); end
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_inputs();
            sb.st_valid = 1'b1; sb.st_addr = 64'(i * 8); sb.st_data = 64'(100 + i);
            #1;
            n_checks++; if (sb.st_ready !== (i < 4)) begin n_fail++; $display("FAIL ovf_st_ready[%0d]: got %b want %b", i, sb.st_ready, (i < 4)); end
            tick();
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (count !== 3'd4 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_state: got %0d/%b want 4/1", count, ovf); end
        n_checks++; if (sb.mem_waddr !== 64'h0 || sb.mem_wdata !== 64'd100) begin n_fail++; $display("FAIL ovf_head: got %h/%0d want 0/100", sb.mem_waddr, sb.mem_wdata); end
        tick();
    endtask

    task automatic test_full_enq_deq();
        logic [AW-1:0] exp_a [4] = '{64'h8, 64'h10, 64'h18, 64'h30};
        logic [DW-1:0] exp_d [4] = '{64'd101, 64'd102, 64'd103, 64'd201};
        @(negedge clk);
        idle_inputs();
        sb.st_valid = 1'b1; sb.st_addr = 64'h28; sb.st_data = 64'd200; sb.mem_wready = 1'b1;
        #1;
        n_checks++; if (sb.st_ready !== 1'b0) begin n_fail++; $display("FAIL full_deq_ready: got %b want 0", sb.st_ready); end
        tick();
        @(negedge clk);
        idle_inputs();
        sb.st_valid = 1'b1; sb.st_addr = 64'h30; sb.st_data = 64'd201;
        #1;
        n_checks++; if (count !== 3'd3 || sb.st_ready !== 1'b1) begin n_fail++; $display("FAIL full_deq_count3: got %0d/%b want 3/1", count, sb.st_ready); end
        tick();
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_refill_count4: got %0d want 4", count); end
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_inputs();
            sb.mem_wready = 1'b1;
            #1;
            n_checks++; if (sb.mem_wvalid !== 1'b1 || sb.mem_waddr !== exp_a[i] || sb.mem_wdata !== exp_d[i])
                begin n_fail++; $display("FAIL drain_order[%0d]: got %b %h %0d want 1 %h %0d", i, sb.mem_wvalid, sb.mem_waddr, sb.mem_wdata, exp_a[i], exp_d[i]); end
            tick();
        end
    endtask

    task automatic test_forward();
        do_reset();
        push(64'h40, 64'd1, 1'b0);
        push(64'h44, 64'd2, 1'b0);
        @(negedge clk);
        idle_inputs();
        sb.st_valid = 1'b1; sb.st_addr = 64'h80; sb.st_data = 64'd5;
        sb.ld_valid = 1'b1; sb.ld_addr = 64'h40;
        #1;
        n_checks++; if (sb.ld_hit !== 1'b1 || sb.ld_data !== 64'd2) begin n_fail++; $display("FAIL fwd_youngest: got %b/%0d want 1/2", sb.ld_hit, sb.ld_data); end
        tick();
        @(negedge clk);
        idle_inputs();
        sb.st_valid = 1'b1; sb.st_addr = 64'hC0; sb.st_data = 64'd7;
        sb.ld_valid = 1'b1; sb.ld_addr = 64'hC0;
        #1;
        n_checks++; if (sb.ld_hit !== 1'b0 || sb.ld_data !== '0) begin n_fail++; $display("FAIL fwd_same_cycle_store: got %b/%0d want 0/0", sb.ld_hit, sb.ld_data); end
        tick();
        @(negedge clk);
        idle_inputs();
        sb.ld_valid = 1'b1; sb.ld_addr = 64'h87; sb.mem_wready = 1'b1;
        #1;
        n_checks++; if (sb.ld_hit !== 1'b1 || sb.ld_data !== 64'd5) begin n_fail++; $display("FAIL fwd_hit_80: got %b/%0d want 1/5", sb.ld_hit, sb.ld_data); end
        tick();
        // Head is now 0x44 (data 2) and is being accepted this cycle.
        @(negedge clk);
        idle_inputs();
        sb.ld_valid = 1'b1; sb.ld_addr = 64'h40; sb.mem_wready = 1'b1;
        #1;
        n_checks++; if (sb.ld_hit !== 1'b1 || sb.ld_data !== 64'd2) begin n_fail++; $display("FAIL fwd_head_dequeue: got %b/%0d want 1/2", sb.ld_hit, sb.ld_data); end
        tick();
        @(negedge clk);
        idle_inputs();
        sb.ld_valid = 1'b0; sb.ld_addr = 64'h80;
        #1;
        n_checks++; if (sb.ld_hit !== 1'b0 || sb.ld_data !== '0) begin n_fail++; $display("FAIL fwd_no_ld_valid: got %b/%0d want 0/0", sb.ld_hit, sb.ld_data); end
        sb.ld_valid = 1'b1; sb.ld_addr = 64'h48;
        #1;
        n_checks++; if (sb.ld_hit !== 1'b0 || sb.ld_data !== '0) begin n_fail++; $display("FAIL fwd_miss: got %b/%0d want 0/0", sb.ld_hit, sb.ld_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(64'h100, 64'd11, 1'b0);
        push(64'h108, 64'd12, 1'b0);
        push(64'h110, 64'd13, 1'b0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        sb.st_valid = 1'b1; sb.st_addr = 64'h118; sb.st_data = 64'd14; sb.mem_wready = 1'b0;
        #1;
        n_checks++; if (count !== 3'd3 || sb.mem_wvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %0d/%b want 3/1", count, sb.mem_wvalid); end
        tick();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        sb.ld_valid = 1'b1; sb.ld_addr = 64'h108;
        #1;
        n_checks++; if (count !== 3'd0 || sb.mem_wvalid !== 1'b0 || sb.ld_hit !== 1'b0)
            begin n_fail++; $display("FAIL mid_post: got %0d/%b/%b want 0/0/0", count, sb.mem_wvalid, sb.ld_hit); end
        tick();
    endtask

    task automatic test_random();
        bit            e_hit;
        logic [DW-1:0] e_data;
        int            n_wr = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            sb.st_valid   = ($urandom_range(0, 3) != 0);
            sb.st_addr    = 64'($urandom_range(0, 63));
            sb.st_data    = {$urandom, $urandom};
            sb.ld_valid   = $urandom_range(0, 1) != 0;
            sb.ld_addr    = 64'($urandom_range(0, 63));
            sb.mem_wready = $urandom_range(0, 1) != 0;
            #1;
            m_fwd(sb.ld_addr, e_hit, e_data);
            e_hit  = e_hit && sb.ld_valid;
            e_data = e_hit ? e_data : '0;
            n_checks++; if (count !== 3'(mq.size()) || count > 3'(DEPTH)) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count, mq.size()); end
            n_checks++; if (sb.st_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_st_ready[%0d]: got %b want %b", c, sb.st_ready, (mq.size() < DEPTH)); end
            n_checks++; if (sb.mem_wvalid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_mem_wvalid[%0d]: got %b want %b", c, sb.mem_wvalid, (mq.size() > 0)); end
            if (mq.size() > 0) begin
                n_checks++; if (sb.mem_waddr !== mq[0].a || sb.mem_wdata !== mq[0].d)
                    begin n_fail++; $display("FAIL rnd_mem_order[%0d]: got %h/%h want %h/%h", c, sb.mem_waddr, sb.mem_wdata, mq[0].a, mq[0].d); end
                if (sb.mem_wready) n_wr++;
            end
            n_checks++; if (sb.ld_hit !== e_hit || sb.ld_data !== e_data) begin n_fail++; $display("FAIL rnd_fwd[%0d]: got %b/%h want %b/%h", c, sb.ld_hit, sb.ld_data, e_hit, e_data); end
            n_checks++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %b want %b", c, ovf, m_ovf); end
            tick();
        end
        n_checks++; if (n_wr < 3 * DEPTH) begin n_fail++; $display("FAIL rnd_drain_volume: got %0d want >= %0d", n_wr, 3 * DEPTH); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        m_ovf = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_full_enq_deq();
        test_forward();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of 2, >=2).
REQ-002 SHALL have parameter AW, default 64, address width.
REQ-003 SHALL have parameter DW, default 64, data width.
REQ-004 SHALL have a single clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 st_valid  in  1  core store request (MemWrite).
REQ-008 st_addr  in  AW  store byte address (core ALU result).
REQ-009 st_data  in  DW  store data (core register read port 2).
REQ-010 st_ready  out  1  buffer can accept a store.
REQ-011 ld_valid  in  1  core load in progress.
REQ-012 ld_addr  in  AW  load byte address.
REQ-013 ld_hit  out  1  load matches a buffered store.
REQ-014 ld_data  out  DW  forwarded store data.
REQ-015 mem_wvalid  out  1  write request to data memory.
REQ-016 mem_waddr  out  AW  write address.
REQ-017 mem_wdata  out  DW  write data.
REQ-018 mem_wready  in  1  memory accepts write.
REQ-019 count  out  $clog2(DEPTH)+1  occupied entries.
REQ-020 ovf  out  1  sticky: store offered while full.

Function
REQ-021 SHALL be a circular FIFO: head (oldest) and tail pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; full = (count==DEPTH), empty = (count==0).
REQ-022 st_ready SHALL equal !full, combinationally, independent of a same-cycle dequeue.
REQ-023 Enqueue on st_valid && st_ready: entry[tail] <= {st_addr, st_data}, valid set, tail+1.
REQ-024 Dequeue on mem_wvalid && mem_wready: valid[head] cleared, head+1.
REQ-025 count SHALL be +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-026 mem_wvalid = !empty; mem_waddr/mem_wdata = entry[head]; held stable until accepted.
REQ-027 Enqueue-to-mem_wvalid latency SHALL be 1 cycle; no same-cycle bypass when empty.
REQ-028 st_valid while full SHALL drop the store, leave state unchanged and set ovf (sticky until reset).
REQ-029 Forwarding, combinational: match if entry valid and entry addr[AW-1:3] == ld_addr[AW-1:3]; ld_hit = ld_valid && any match.
REQ-030 On multiple matches ld_data SHALL be the youngest (closest to tail) entry; ld_data = 0 when !ld_hit.
REQ-031 Entry at head being dequeued in the current cycle SHALL still be eligible for match.
REQ-032 Store being enqueued in the current cycle SHALL NOT be eligible for match.
REQ-033 Stores SHALL drain to memory strictly in enqueue order; no coalescing.

Reset
REQ-034 On reset: head, tail, count = 0; all valid bits = 0; ovf = 0; entry contents = 0.
REQ-035 After reset: st_ready = 1, mem_wvalid = 0, mem_waddr = 0, mem_wdata = 0, ld_hit = 0, ld_data = 0.
REQ-036 Reset mid-drain SHALL discard all buffered stores, including an unaccepted head; reset dominates enqueue/dequeue in the same cycle.

Structure
REQ-037 Shared package SHALL hold DEPTH default, AW/DW defaults, and the doubleword-offset constant (3).
REQ-038 Youngest-match priority select SHALL be one sub-module, sb_fwd_match (inputs: valid vector, addresses, data, head, tail, ld_addr; outputs: hit, data).

Verification
REQ-039 Reset, then store 0x10 <- 0xAA with mem_wready=1 -> next cycle mem_wvalid=1, mem_waddr=0x10, mem_wdata=0xAA; count back to 0 after accept.
REQ-040 mem_wready=0, 5 stores to 0x0,0x8,0x10,0x18,0x20 -> st_ready=0 after 4th, 5th dropped, ovf=1, count=4.
REQ-041 mem_wready=0, stores 0x40<-1 then 0x44<-2, load 0x40 -> ld_hit=1, ld_data=2 (youngest, same doubleword).
REQ-042 Full buffer, st_valid and mem_wready both high -> store dropped, dequeue occurs, count=3; next cycle store accepted, count=4.
REQ-043 Fill/drain 3*DEPTH stores with random mem_wready -> memory sees all in order, pointers wrap, count never exceeds DEPTH.
REQ-044 Reset asserted with 3 entries and mem_wvalid=1, mem_wready=0 -> next cycle count=0, mem_wvalid=0, ld_hit=0.
